shift_unit: RTL and testbench

//   Parametrised multi-mode shifter for the Elements Catalog; generalises the 1-bit SLL to
//   SLL/SRL/SRA/ROL/ROR with a multi-bit amount. Iterative: STEP bits per cycle, so area

---
 rtl/shift_unit.sv | 158 +++++++++++++++
 tb/tb_shift_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// ---------------------------------------------------------------------------
// shift_unit
//   Iterative multi-mode shifter (SLL, SRL, SRA, ROL, ROR) with a multi-bit
//   shift amount. Each cycle in SHIFT moves the accumulator by up to STEP bit
//   positions, so the shifting datapath only spans STEP positions.
//   There are valid/ready handshakes on both the request side and the result side.
//
// Parameters
//   N     data width in bits (>= 2)
//   STEP  maximum bit positions shifted per cycle (1..N)
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid && in_ready (IDLE only)
//   d          operand, captured on accept
//   amt        shift amount 0..N-1, captured on accept
//   mode       000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others pass-through
//   out_valid  result valid, held until out_ready
//   out_ready  consumer ready
//   out        result register, written only when entering DONE
//   busy       high while shifting
// ---------------------------------------------------------------------------
module shift_unit #(
    parameter int N    = 8,
    parameter int STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         d,
    input  logic [$clog2(N)-1:0] amt,
    input  logic [2:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out,
    output logic                 busy
);

    localparam int AW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [2:0]    mode_q, mode_d;
    logic [N-1:0]  out_q, out_d;

    logic [AW-1:0] step_s;
    logic [N-1:0]  shifted;

    // One shift/rotate of a by s positions. Rotates are taken from a doubled
    // copy of the operand so the wrapped bits fall out of the shift itself.
    function automatic logic [N-1:0] apply_op(input logic [N-1:0]  a,
                                              input logic [AW-1:0] s,
                                              input logic [2:0]    m);
        logic [2*N-1:0] dbl;
        dbl = {a, a};
        case (m)
            3'b000:  return a << s;
            3'b001:  return a >> s;
            3'b010:  return $signed(a) >>> s;
            3'b011: begin
                dbl = dbl << s;
                return dbl[2*N-1:N];
            end
            3'b100: begin
                dbl = dbl >> s;
                return dbl[N-1:0];
            end
            default: return a;
        endcase
    endfunction

    // Amount applied this cycle: min(STEP, remaining). The truncating cast is
    // only reached when STEP < rem_q, so STEP fits in AW bits there.
    always_comb begin
        step_s = rem_q;
        if (int'(rem_q) > STEP) begin
            step_s = AW'(STEP);
        end
    end

    assign shifted = apply_op(acc_q, step_s, mode_q);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        mode_d    = mode_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d  = d;
                    rem_d  = amt;
                    mode_d = mode;
                    // Zero amount or reserved mode: the result is the operand.
                    if (amt == '0 || mode > 3'd4) begin
                        state_d = DONE;
                        out_d   = d;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                busy  = 1'b1;
                acc_d = shifted;
                rem_d = rem_q - step_s;
                if (rem_q == step_s) begin
                    state_d = DONE;
                    out_d   = shifted;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_shift_unit
//   Testbench for shift_unit. Two instances are exercised: one with STEP=1
//   and one with STEP=4, both with N=8. They share the operand, amount, mode
//   and out_ready inputs, and each has its own in_valid. Results and latencies
//   are compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_shift_unit;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iv1 = 1'b0;
    logic       iv4 = 1'b0;
    logic [7:0] d = '0;
    logic [2:0] amt = '0;
    logic [2:0] mode = '0;
    logic       out_ready = 1'b0;

    logic       ir1, ov1, bz1;
    logic [7:0] o1;
    logic       ir4, ov4, bz4;
    logic [7:0] o4;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    shift_unit #(.N(N), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .d(d), .amt(amt),
        .mode(mode), .out_valid(ov1), .out_ready(out_ready), .out(o1), .busy(bz1)
    );

    shift_unit #(.N(N), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .d(d), .amt(amt),
        .mode(mode), .out_valid(ov4), .out_ready(out_ready), .out(o4), .busy(bz4)
    );

    // Reference result from plain integer arithmetic on the operand value.
    function automatic logic [7:0] model_res(input logic [7:0] x, input int a, input int m);
        int v;
        int r;
        v = int'(x);
        case (m)
            0: r = (v * (1 << a)) % 256;
            1: r = v / (1 << a);
            2: r = v / (1 << a) + ((v >= 128) ? (256 - (256 >> a)) : 0);
            3: r = ((v << a) | (v >> (8 - a))) % 256;
            4: r = ((v >> a) | (v << (8 - a))) % 256;
            default: r = v;
        endcase
        return 8'(r);
    endfunction

    function automatic int model_lat(input int a, input int m, input int step);
        if (a == 0 || m > 4) return 1;
        return 1 + (a + step - 1) / step;
    endfunction

    // Issue one request to instance 1 or 4. lat counts edges from the accept
    // edge (inclusive) until out_valid is seen; busy_n counts cycles with busy.
    // Unless hold is set, the result is then consumed with one out_ready pulse.
    task automatic do_op(input int which, input logic [7:0] dv, input logic [2:0] av,
                         input logic [2:0] mv, input bit hold,
                         output logic [7:0] res, output int lat, output int busy_n);
        @(negedge clk);
        d    = dv;
        amt  = av;
        mode = mv;
        if (which == 4) iv4 = 1'b1; else iv1 = 1'b1;
        @(posedge clk);
        #1;
        iv1    = 1'b0;
        iv4    = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!((which == 4) ? ov4 : ov1)) begin
            if ((which == 4) ? bz4 : bz1) busy_n++;
            if (lat > 40) break;
            @(posedge clk);
            #1;
            lat++;
        end
        res = (which == 4) ? o4 : o1;
        if (!hold) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_total++;
        if ({o1, ov1, bz1} !== 10'b0) $display("FAIL reset_dut1 got out=%h ov=%b busy=%b want 0/0/0", o1, ov1, bz1);
        else n_pass++;
        n_total++;
        if ({o4, ov4, bz4} !== 10'b0) $display("FAIL reset_dut4 got out=%h ov=%b busy=%b want 0/0/0", o4, ov4, bz4);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if ({ir1, ir4} !== 2'b11) $display("FAIL reset_in_ready got %b want 11", {ir1, ir4});
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [7:0] res;
        int lat, bn;
        logic [7:0] vd [7]  = '{8'hB3, 8'h90, 8'h90, 8'h81, 8'h81, 8'h3C, 8'h5A};
        logic [2:0] va [7]  = '{3'd3, 3'd2, 3'd2, 3'd1, 3'd7, 3'd0, 3'd4};
        logic [2:0] vm [7]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd7};
        logic [7:0] vr [7]  = '{8'h98, 8'h24, 8'hE4, 8'h03, 8'h03, 8'h3C, 8'h5A};
        int         vl [7]  = '{4, 3, 3, 2, 8, 1, 1};
        for (int i = 0; i < 7; i++) begin
            do_op(1, vd[i], va[i], vm[i], 1'b0, res, lat, bn);
            n_total++;
            if (res !== vr[i]) $display("FAIL directed_res[%0d] got %h want %h", i, res, vr[i]);
            else n_pass++;
            n_total++;
            if (lat !== vl[i]) $display("FAIL directed_lat[%0d] got %0d want %0d", i, lat, vl[i]);
            else n_pass++;
            if (i == 0) begin
                n_total++;
                if (bn !== 3) $display("FAIL directed_busy got %0d want 3", bn);
                else n_pass++;
            end
        end
    endtask

    task automatic test_step4();
        logic [7:0] res;
        int lat, bn;
        do_op(4, 8'hFF, 3'd7, 3'd0, 1'b0, res, lat, bn);
        n_total++;
        if (res !== 8'h80) $display("FAIL step4_res got %h want 80", res);
        else n_pass++;
        n_total++;
        if (lat !== 3) $display("FAIL step4_lat got %0d want 3", lat);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] res, x;
        int lat, bn, a, m, which, step;
        for (int i = 0; i < 60; i++) begin
            which = (i % 2 == 0) ? 1 : 4;
            step  = (which == 4) ? 4 : 1;
            x = 8'($urandom);
            a = $urandom_range(0, 7);
            m = $urandom_range(0, 7);
            do_op(which, x, 3'(a), 3'(m), 1'b0, res, lat, bn);
            n_total++;
            if (res !== model_res(x, a, m))
                $display("FAIL random_res dut%0d d=%h amt=%0d mode=%0d got %h want %h",
                         which, x, a, m, res, model_res(x, a, m));
            else n_pass++;
            n_total++;
            if (lat !== model_lat(a, m, step))
                $display("FAIL random_lat dut%0d amt=%0d mode=%0d got %0d want %0d",
                         which, a, m, lat, model_lat(a, m, step));
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        logic [7:0] res;
        int lat, bn;
        do_op(1, 8'hC3, 3'd2, 3'd3, 1'b1, res, lat, bn);
        n_total++;
        if (res !== 8'h0F) $display("FAIL hold_res got %h want 0f", res);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv1  = 1'b1;
            d    = 8'($urandom);
            amt  = 3'($urandom);
            mode = 3'($urandom);
            @(posedge clk);
            #1;
            iv1 = 1'b0;
            n_total++;
            if ({o1, ov1, ir1} !== {8'h0F, 1'b1, 1'b0})
                $display("FAIL hold_stable[%0d] got out=%h ov=%b ir=%b want 0f/1/0", i, o1, ov1, ir1);
            else n_pass++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_total++;
        if ({o1, ov1, ir1} !== {8'h0F, 1'b0, 1'b1})
            $display("FAIL hold_release got out=%h ov=%b ir=%b want 0f/0/1", o1, ov1, ir1);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if ({ov1, bz1} !== 2'b00) $display("FAIL hold_dropped got ov=%b busy=%b want 0/0", ov1, bz1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] res;
        int lat, bn;
        @(negedge clk);
        d    = 8'h01;
        amt  = 3'd7;
        mode = 3'd0;
        iv1  = 1'b1;
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (bz1 !== 1'b1) $display("FAIL midreset_busy_before got %b want 1", bz1);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if ({o1, ov1, bz1} !== 10'b0)
            $display("FAIL midreset_clear got out=%h ov=%b busy=%b want 0/0/0", o1, ov1, bz1);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        do_op(1, 8'h80, 3'd3, 3'd2, 1'b0, res, lat, bn);
        n_total++;
        if (res !== 8'hF0) $display("FAIL midreset_next_res got %h want f0", res);
        else n_pass++;
        n_total++;
        if (lat !== 4) $display("FAIL midreset_next_lat got %0d want 4", lat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_step4();
        test_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
